// File: rtl/scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
// Shared definitions for the SCAN frame sequencer:
//   state_t : frame sequencer states (IDLE, CLR, LOAD, DECODE, DRAIN, OUT)
//   cnt_w() : counter width helper, never returns less than 1 bit
//   *_DEF   : default configuration and the counter widths it implies
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOAD   = 3'd2,
    DECODE = 3'd3,
    DRAIN  = 3'd4,
    OUT    = 3'd5
  } state_t;

  // Bits needed to hold the values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_DEF           = 1024;
  localparam int ITER_CYCLES_DEF = 1536;
  localparam int I_MAX_DEF       = 4;
  localparam int LAT_DEF         = 2;

  localparam int LD_W_DEF   = cnt_w(N_DEF);
  localparam int CYC_W_DEF  = cnt_w(ITER_CYCLES_DEF + 2);
  localparam int ITER_W_DEF = cnt_w(I_MAX_DEF + 1);

endpackage

// File: rtl/scan_iter_timer.sv
// -----------------------------------------------------------------------------
// scan_iter_timer
// Counts decoder-core clocks within a SCAN iteration and completed iterations.
// The first iteration of a frame is two clocks longer because the core's
// program counter starts at -2; later iterations reload the cycle counter to 2
// so every iteration ends on the same count.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_clr        : zero both counters (frame start)
//   i_run        : core is decoding this cycle
//   o_boundary   : last cycle of the current iteration (only while i_run)
//   o_last       : the iteration in progress is number I_MAX
//   o_iter_cnt   : iterations completed so far in this frame
// -----------------------------------------------------------------------------
module scan_iter_timer
  import scan_ctrl_pkg::*;
#(
  parameter int ITER_CYCLES = ITER_CYCLES_DEF,
  parameter int I_MAX       = I_MAX_DEF,
  localparam int CYC_W      = cnt_w(ITER_CYCLES + 2),
  localparam int IT_W       = cnt_w(I_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_run,
  output logic            o_boundary,
  output logic            o_last,
  output logic [IT_W-1:0] o_iter_cnt
);

  localparam logic [CYC_W-1:0] CYC_END    = CYC_W'(ITER_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_RELOAD = CYC_W'(2);
  localparam logic [IT_W-1:0]  IT_LAST    = IT_W'(I_MAX - 1);

  logic [CYC_W-1:0] r_cyc_cnt;
  logic [IT_W-1:0]  r_iter_cnt;

  assign o_boundary = i_run && (r_cyc_cnt == CYC_END);
  assign o_last     = (r_iter_cnt == IT_LAST);
  assign o_iter_cnt = r_iter_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cyc_cnt  <= '0;
      r_iter_cnt <= '0;
    end else if (i_run) begin
      if (o_boundary) begin
        r_cyc_cnt  <= CYC_RELOAD;
        r_iter_cnt <= r_iter_cnt + 1'b1;
      end else begin
        r_cyc_cnt  <= r_cyc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_frame_ctrl.sv
// -----------------------------------------------------------------------------
// scan_frame_ctrl
// Frame sequencer around the SCAN L=2 polar decoder core. Streams N channel
// LLRs into the core, runs up to I_MAX SCAN iterations, waits LAT drain
// cycles, then offers the decoded word with the iteration count used.
// Optional build macro: SCAN_EARLY_STOP_EN -- stop once two consecutive
// iteration results agree (snapshot register compared at each boundary).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   s_valid/s_ready    : LLR input handshake, s_llr the LLR beat (Q bits)
//   dec_rst            : decoder core reset (high in CLR and after reset)
//   dec_channel        : 0 = core loads LLRs, 1 = core decodes
//   dec_llr            : LLR to the core (pass-through while loading, else 0)
//   dec_bits           : decoded word from the core (N bits)
//   m_valid/m_ready    : output frame handshake, m_bits/m_iters held stable
//   busy               : sequencer not idle
//   err                : sticky load-underrun flag, cleared only by rst
// -----------------------------------------------------------------------------
module scan_frame_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int Q           = 6,
  parameter int ITER_CYCLES = ITER_CYCLES_DEF,
  parameter int I_MAX       = I_MAX_DEF,
  parameter int LAT         = LAT_DEF,
  localparam int IT_W       = cnt_w(I_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [Q-1:0]    s_llr,
  output logic            dec_rst,
  output logic            dec_channel,
  output logic [Q-1:0]    dec_llr,
  input  logic [N-1:0]    dec_bits,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N-1:0]    m_bits,
  output logic [IT_W-1:0] m_iters,
  output logic            busy,
  output logic            err
);

  localparam int LD_W  = cnt_w(N);
  localparam int DRN_W = cnt_w(LAT + 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(N - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LAT - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic [LD_W-1:0]   r_ld_cnt;
  logic [DRN_W-1:0]  r_drn_cnt;
  logic              r_s_ready;
  logic              r_dec_rst;
  logic              r_dec_channel;
  logic              r_m_valid;
  logic              r_err;
  logic [N-1:0]      r_m_bits;
  logic [IT_W-1:0]   r_m_iters;

  logic              w_boundary;
  logic              w_last;
  logic              w_stop;
  logic [IT_W-1:0]   w_iter_cnt;

  scan_iter_timer #(
    .ITER_CYCLES (ITER_CYCLES),
    .I_MAX       (I_MAX)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == CLR),
    .i_run      (r_state == DECODE),
    .o_boundary (w_boundary),
    .o_last     (w_last),
    .o_iter_cnt (w_iter_cnt)
  );

`ifdef SCAN_EARLY_STOP_EN
  // Result of the previous iteration; only meaningful once one boundary passed.
  logic [N-1:0] r_snap;

  always_ff @(posedge clk) begin
    if (w_boundary) r_snap <= dec_bits;
  end

  assign w_stop = w_last || ((w_iter_cnt != '0) && (dec_bits == r_snap));
`else
  assign w_stop = w_last;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (s_valid) w_nxt = CLR;
      CLR:     w_nxt = LOAD;
      // The core samples an LLR every cycle, so any gap aborts the load.
      LOAD:    if (!s_valid) w_nxt = CLR;
               else if (r_ld_cnt == LD_LAST) w_nxt = DECODE;
      DECODE:  if (w_boundary && w_stop) w_nxt = DRAIN;
      DRAIN:   if (r_drn_cnt == DRN_LAST) w_nxt = OUT;
      // m_valid is always high in OUT; a waiting beat skips the IDLE bubble.
      OUT:     if (m_ready) w_nxt = s_valid ? CLR : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_s_ready     <= 1'b0;
      r_dec_rst     <= 1'b1;
      r_dec_channel <= 1'b0;
      r_m_valid     <= 1'b0;
      r_err         <= 1'b0;
      r_ld_cnt      <= '0;
      r_drn_cnt     <= '0;
      r_m_bits      <= '0;
      r_m_iters     <= '0;
    end else begin
      r_state       <= w_nxt;
      r_s_ready     <= (w_nxt == LOAD);
      r_dec_rst     <= (w_nxt == CLR);
      r_dec_channel <= (w_nxt == DECODE) || (w_nxt == DRAIN);
      r_m_valid     <= (w_nxt == OUT);

      if ((r_state == LOAD) && !s_valid) r_err <= 1'b1;

      if (r_state == CLR)
        r_ld_cnt <= '0;
      else if ((r_state == LOAD) && s_valid && (r_ld_cnt != LD_LAST))
        r_ld_cnt <= r_ld_cnt + 1'b1;

      if (r_state == CLR)
        r_drn_cnt <= '0;
      else if (r_state == DRAIN)
        r_drn_cnt <= r_drn_cnt + 1'b1;

      if ((r_state == DRAIN) && (w_nxt == OUT)) begin
        r_m_bits  <= dec_bits;
        r_m_iters <= w_iter_cnt;
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign dec_rst     = r_dec_rst;
  assign dec_channel = r_dec_channel;
  assign dec_llr     = r_s_ready ? s_llr : '0;
  assign m_valid     = r_m_valid;
  assign m_bits      = r_m_bits;
  assign m_iters     = r_m_iters;
  assign busy        = (r_state != IDLE);
  assign err         = r_err;

endmodule
